// File: rtl/rpn_pkg.sv
// Shared constants for the RPN operand-stack controller: opcodes, error codes,
// default data width and the controller state encoding.
package rpn_pkg;

    localparam int RPN_WIDTH = 8;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_NEG   = 4'd6;
    localparam logic [3:0] OP_DUP   = 4'd7;
    localparam logic [3:0] OP_SWAP  = 4'd8;
    localparam logic [3:0] OP_CLEAR = 4'd9;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/rpn_stack_sequencer_if.sv
// Command/status bundle between the instruction decoder (master) and the
// operand-stack controller (slave).
interface rpn_stack_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int DW = $clog2(DEPTH + 1);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [3:0]              cmd_op;
    logic signed [WIDTH-1:0] cmd_data;
    logic signed [WIDTH-1:0] top;
    logic [DW-1:0]           depth;
    logic                    err_valid;
    logic [1:0]              err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, top, depth, err_valid, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, top, depth, err_valid, err_code
    );
endinterface

// File: rtl/rpn_stack_ram.sv
// Single-port stack RAM holding the entries below top-of-stack:
// synchronous write, registered read (1-cycle latency).
module rpn_stack_ram #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 15,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/rpn_stack_sequencer.sv
// Operand-stack controller: keeps TOS in a register, spills lower entries to
// the stack RAM and sequences read ops through IDLE -> FETCH -> EXEC.
module rpn_stack_sequencer
    import rpn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = RPN_WIDTH
) (
    input logic                 clk,
    input logic                 resetn,
    rpn_stack_sequencer_if.slave bus
);
    localparam int DW      = $clog2(DEPTH + 1);
    localparam int ENTRIES = DEPTH - 1;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    state_t                  state, state_nx;
    logic signed [WIDTH-1:0] tos, tos_nx;
    logic [DW-1:0]           dep, dep_nx;
    logic [3:0]              op_q, op_nx;
    logic                    err_vld_p1, err_vld_nx;
    logic [1:0]              err_code_p1, err_code_nx;

    logic [AW-1:0]           ram_addr, wr_idx, nos_idx;
    logic                    ram_we;
    logic [WIDTH-1:0]        ram_wdata, ram_rdata;
    logic signed [WIDTH-1:0] nos;

    function automatic logic signed [WIDTH-1:0] wrap_mul(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        return p[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] alu(
        input logic [3:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return wrap_mul(a, b);
            default: return a;
        endcase
    endfunction

    rpn_stack_ram #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .AW(AW)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we && resetn),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign nos     = ram_rdata;
    assign wr_idx  = (dep != '0)         ? AW'(dep - DW'(1)) : '0;
    assign nos_idx = (dep >= DW'(2))     ? AW'(dep - DW'(2)) : '0;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.top       = tos;
    assign bus.depth     = dep;
    assign bus.err_valid = err_vld_p1;
    assign bus.err_code  = err_code_p1;

    always_comb begin
        state_nx    = state;
        tos_nx      = tos;
        dep_nx      = dep;
        op_nx       = op_q;
        err_vld_nx  = 1'b0;
        err_code_nx = ERR_NONE;
        ram_we      = 1'b0;
        ram_addr    = nos_idx;
        ram_wdata   = tos;

        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op > OP_CLEAR) begin
                        err_vld_nx  = 1'b1;
                        err_code_nx = ERR_ILLEGAL;
                    end else begin
                        case (bus.cmd_op)
                            OP_PUSH, OP_DUP: begin
                                if (dep == FULL) begin
                                    err_vld_nx  = 1'b1;
                                    err_code_nx = ERR_OVERFLOW;
                                end else begin
                                    // An empty stack has nothing to spill below TOS.
                                    ram_we   = (dep != '0);
                                    ram_addr = wr_idx;
                                    tos_nx   = (bus.cmd_op == OP_PUSH) ? bus.cmd_data : tos;
                                    dep_nx   = dep + DW'(1);
                                end
                            end
                            OP_NEG: begin
                                if (dep == '0) begin
                                    err_vld_nx  = 1'b1;
                                    err_code_nx = ERR_UNDERFLOW;
                                end else begin
                                    tos_nx = -tos;
                                end
                            end
                            OP_CLEAR: begin
                                tos_nx = '0;
                                dep_nx = '0;
                            end
                            OP_POP: begin
                                if (dep == '0) begin
                                    err_vld_nx  = 1'b1;
                                    err_code_nx = ERR_UNDERFLOW;
                                end else begin
                                    op_nx    = bus.cmd_op;
                                    state_nx = ST_FETCH;
                                end
                            end
                            OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
                                if (dep < DW'(2)) begin
                                    err_vld_nx  = 1'b1;
                                    err_code_nx = ERR_UNDERFLOW;
                                end else begin
                                    op_nx    = bus.cmd_op;
                                    state_nx = ST_FETCH;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_FETCH: begin
                state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                state_nx = ST_IDLE;
                if (op_q == OP_SWAP) begin
                    ram_we = 1'b1;
                    tos_nx = nos;
                end else begin
                    // POP of the last entry reads a stale RAM word; force an empty TOS.
                    if (op_q == OP_POP && dep == DW'(1)) begin
                        tos_nx = '0;
                    end else begin
                        tos_nx = alu(op_q, nos, tos);
                    end
                    dep_nx = dep - DW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            tos         <= '0;
            dep         <= '0;
            op_q        <= OP_NOP;
            err_vld_p1  <= 1'b0;
            err_code_p1 <= ERR_NONE;
        end else begin
            state       <= state_nx;
            tos         <= tos_nx;
            dep         <= dep_nx;
            op_q        <= op_nx;
            err_vld_p1  <= err_vld_nx;
            err_code_p1 <= err_code_nx;
        end
    end
endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Self-checking bench for rpn_stack_sequencer: vector table plus hand-written
// throughput and reset-abort sequences, checked through an expectation queue.
module tb_rpn_stack_sequencer;
    import rpn_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        logic [7:0] top;
        int         depth;
        logic [1:0] err;
        int         busy;
    } vec_t;

    logic clk;
    logic resetn;
    int   tests;
    int   fails;
    vec_t sb[$];

    rpn_stack_sequencer_if #(.WIDTH(8), .DEPTH(16)) bus ();

    rpn_stack_sequencer #(.DEPTH(16), .WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] data,
                                input logic [7:0] top, input int depth,
                                input logic [1:0] err, input int busy);
        vec_t v;
        v.op = op; v.data = data; v.top = top; v.depth = depth; v.err = err; v.busy = busy;
        return v;
    endfunction

    task automatic run_cmd(input vec_t v, input string name);
        int   wait_cnt;
        int   busy;
        logic ev;
        logic [1:0] ec;
        vec_t e;
        @(negedge clk);
        wait_cnt = 0;
        while (!bus.cmd_ready && wait_cnt < 20) begin
            wait_cnt++;
            @(negedge clk);
        end
        if (!bus.cmd_ready) begin
            chk({name, "_ready_timeout"}, 32'(bus.cmd_ready), 32'd1);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_data  = v.data;
        sb.push_back(v);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        ev   = bus.err_valid;
        ec   = bus.err_code;
        busy = 0;
        while (!bus.cmd_ready && busy < 10) begin
            busy++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({name, "_top"},   {24'h0, bus.top},  {24'h0, e.top});
        chk({name, "_depth"}, 32'(bus.depth),    32'(e.depth));
        chk({name, "_errv"},  32'(ev),           32'(e.err != 2'd0));
        chk({name, "_errc"},  32'(ec),           32'(e.err));
        chk({name, "_busy"},  32'(busy),         32'(e.busy));
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    vec_t tbl[$];
    vec_t e;
    logic [7:0] sum;

    initial begin
        tests = 0;
        fails = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_data  = '0;
        do_reset();

        @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_top",   {24'h0, bus.top},   32'd0);
        chk("rst_depth", 32'(bus.depth),     32'd0);
        chk("rst_errv",  32'(bus.err_valid), 32'd0);
        chk("rst_errc",  32'(bus.err_code),  32'd0);

        // op, data, expected top, depth, error code, cycles with cmd_ready low
        tbl.push_back(mk(OP_PUSH,  8'd5,   8'd5,   1, 2'd0, 0));
        tbl.push_back(mk(OP_PUSH,  8'hFD, 8'hFD,  2, 2'd0, 0));
        tbl.push_back(mk(OP_SUB,   8'd0,   8'd8,   1, 2'd0, 2));
        tbl.push_back(mk(OP_CLEAR, 8'd0,   8'd0,   0, 2'd0, 0));
        tbl.push_back(mk(OP_PUSH,  8'd12,  8'd12,  1, 2'd0, 0));
        tbl.push_back(mk(OP_PUSH,  8'd11,  8'd11,  2, 2'd0, 0));
        tbl.push_back(mk(OP_MUL,   8'd0,   8'h84,  1, 2'd0, 2));
        tbl.push_back(mk(OP_CLEAR, 8'd0,   8'd0,   0, 2'd0, 0));
        tbl.push_back(mk(OP_POP,   8'd0,   8'd0,   0, 2'd1, 0));
        tbl.push_back(mk(OP_PUSH,  8'd7,   8'd7,   1, 2'd0, 0));
        tbl.push_back(mk(OP_ADD,   8'd0,   8'd7,   1, 2'd1, 0));
        tbl.push_back(mk(4'd12,    8'd0,   8'd7,   1, 2'd3, 0));
        tbl.push_back(mk(OP_SWAP,  8'd0,   8'd7,   1, 2'd1, 0));
        tbl.push_back(mk(OP_NEG,   8'd0,   8'hF9,  1, 2'd0, 0));
        tbl.push_back(mk(OP_CLEAR, 8'd0,   8'd0,   0, 2'd0, 0));
        tbl.push_back(mk(OP_NEG,   8'd0,   8'd0,   0, 2'd1, 0));
        tbl.push_back(mk(OP_PUSH,  8'd1,   8'd1,   1, 2'd0, 0));
        tbl.push_back(mk(OP_PUSH,  8'd2,   8'd2,   2, 2'd0, 0));
        tbl.push_back(mk(OP_SWAP,  8'd0,   8'd1,   2, 2'd0, 2));
        tbl.push_back(mk(OP_POP,   8'd0,   8'd2,   1, 2'd0, 2));
        tbl.push_back(mk(OP_NEG,   8'd0,   8'hFE,  1, 2'd0, 0));
        tbl.push_back(mk(OP_POP,   8'd0,   8'd0,   0, 2'd0, 2));
        tbl.push_back(mk(OP_PUSH,  8'h80, 8'h80,  1, 2'd0, 0));
        tbl.push_back(mk(OP_NEG,   8'd0,   8'h80,  1, 2'd0, 0));
        tbl.push_back(mk(OP_DUP,   8'd0,   8'h80,  2, 2'd0, 0));
        tbl.push_back(mk(OP_ADD,   8'd0,   8'h00,  1, 2'd0, 2));
        tbl.push_back(mk(OP_NOP,   8'd0,   8'h00,  1, 2'd0, 0));
        tbl.push_back(mk(OP_PUSH,  8'hF6, 8'hF6,  2, 2'd0, 0));
        tbl.push_back(mk(OP_PUSH,  8'd13,  8'd13,  3, 2'd0, 0));
        tbl.push_back(mk(OP_MUL,   8'd0,   8'h7E,  2, 2'd0, 2));
        tbl.push_back(mk(OP_PUSH,  8'd3,   8'd3,   3, 2'd0, 0));
        tbl.push_back(mk(OP_SUB,   8'd0,   8'h7B,  2, 2'd0, 2));
        tbl.push_back(mk(OP_SUB,   8'd0,   8'h7B,  0, 2'd0, 2));
        tbl[tbl.size()-1].top = 8'h00 - 8'h7B;
        tbl[tbl.size()-1].depth = 1;
        tbl.push_back(mk(OP_CLEAR, 8'd0,   8'd0,   0, 2'd0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cmd(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back pushes: one accepted per cycle with cmd_valid held high.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i > 1) begin
                e = sb.pop_front();
                chk($sformatf("b2b%0d_top", i - 1),   {24'h0, bus.top}, {24'h0, e.top});
                chk($sformatf("b2b%0d_depth", i - 1), 32'(bus.depth),   32'(e.depth));
            end
            chk($sformatf("b2b%0d_ready", i), 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = OP_PUSH;
            bus.cmd_data  = 8'(i);
            sb.push_back(mk(OP_PUSH, 8'(i), 8'(i), i, 2'd0, 0));
            @(posedge clk);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        e = sb.pop_front();
        chk("b2b16_top",   {24'h0, bus.top}, {24'h0, e.top});
        chk("b2b16_depth", 32'(bus.depth),   32'(e.depth));

        run_cmd(mk(OP_PUSH, 8'd17, 8'd16, 16, 2'd2, 0), "push_full");
        run_cmd(mk(OP_DUP,  8'd0,  8'd16, 16, 2'd2, 0), "dup_full");

        sum = 8'd16;
        for (int k = 1; k <= 15; k++) begin
            sum = sum + 8'(16 - k);
            run_cmd(mk(OP_ADD, 8'd0, sum, 16 - k, 2'd0, 2), $sformatf("add%0d", k));
        end
        chk("sum_final", {24'h0, bus.top}, 32'h88);

        // Reset asserted during FETCH of an ADD aborts the op.
        run_cmd(mk(OP_CLEAR, 8'd0, 8'd0, 0, 2'd0, 0), "clr_a");
        run_cmd(mk(OP_PUSH,  8'd4, 8'd4, 1, 2'd0, 0), "push4");
        run_cmd(mk(OP_PUSH,  8'd9, 8'd9, 2, 2'd0, 0), "push9");
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_fetch_busy", 32'(bus.cmd_ready), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_fetch_top",   {24'h0, bus.top},   32'd0);
        chk("abort_fetch_depth", 32'(bus.depth),     32'd0);
        chk("abort_fetch_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_fetch_errv",  32'(bus.err_valid), 32'd0);

        // Reset asserted during EXEC of a SWAP aborts the op.
        run_cmd(mk(OP_PUSH, 8'd1, 8'd1, 1, 2'd0, 0), "push1");
        run_cmd(mk(OP_PUSH, 8'd2, 8'd2, 2, 2'd0, 0), "push2");
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SWAP;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_exec_busy", 32'(bus.cmd_ready), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_exec_top",   {24'h0, bus.top},   32'd0);
        chk("abort_exec_depth", 32'(bus.depth),     32'd0);
        chk("abort_exec_ready", 32'(bus.cmd_ready), 32'd1);

        run_cmd(mk(OP_PUSH, 8'd6, 8'd6, 1, 2'd0, 0), "post_reset_push");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
